bask_bit_framer: RTL and testbench
==================================

# bask_bit_framer

Upstream bit source for the BASK modulator. Accepts parallel data words through a valid/ready handshake, wraps each word in a frame (alternating preamble, data MSB-first, one guard bit), and emits it as a serial bit stream at a fixed bit period. The registered `bit_out` drives the modulator's `sel` input directly. Carrier on means `1`, carrier off means `0`.

## Interface

Parameters:
- `DATA_W`, default 8: data word width.
- `CLKS_PER_BIT`, default 50: clock cycles per bit. Legal range is 2 or more.
- `PREAMBLE_LEN`, default 4: number of preamble bits. Legal range is 0 or more. The pattern alternates and starts with `1`.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `data_in`, input, `DATA_W`: word to transmit.
- `data_valid`, input, 1: `data_in` is valid.
- `data_ready`, output, 1: block can accept a word.
- `bit_out`, output, 1: serial bit stream to the modulator `sel` input. Registered.
- `bit_strobe`, output, 1: one-cycle pulse in the first cycle of every frame bit.
- `busy`, output, 1: a frame is in progress.

## Operation

Reset: while `rst`=0 at a rising edge, the following take effect on that edge:
- `bit_out`=0, `bit_strobe`=0, `busy`=0, `data_ready`=1.
- State returns to IDLE and all counters clear.
- Reset mid-frame aborts the frame. The partial word is discarded and never resumed.

Handshake:
- A word is accepted on a rising edge where `data_valid`=1 and `data_ready`=1.
- `data_ready` is 1 only in IDLE.
- `data_in` is captured into a shift register at accept. Later changes to `data_in` have no effect on the frame.
- `data_valid` asserted while busy is ignored. No queuing.

FSM states: IDLE, PREAMBLE, DATA, GUARD.
- IDLE: `bit_out`=0. Goes to PREAMBLE on accept, or to DATA on accept when `PREAMBLE_LEN`=0.
- PREAMBLE: preamble bit i (i = 0, 1, …) is `1` when i is even and `0` when i is odd. After `PREAMBLE_LEN` bits, go to DATA.
- DATA: shift out `DATA_W` bits, MSB first. Then go to GUARD.
- GUARD: one bit of `0`. Then go to IDLE.

Bit timing:
- A cycle counter runs from 0 to `CLKS_PER_BIT`-1.
- The bit index advances on wrap.
- `bit_strobe`=1 when the counter is 0 in any state other than IDLE.
- Frame length is F = `PREAMBLE_LEN` + `DATA_W` + 1 bits, which is F × `CLKS_PER_BIT` cycles.

Outputs:
- `busy` = 1 in every state other than IDLE.
- `data_ready` = 1 exactly when `busy` = 0.

Widths:
- Cycle counter: $clog2(`CLKS_PER_BIT`) bits.
- Bit index: $clog2(max(`PREAMBLE_LEN`, `DATA_W`) + 1) bits.
- No counter overflow is permitted at legal parameter values.

## Timing

All cycle numbers below are relative to accept at edge N; C = `CLKS_PER_BIT`.
- Latency: the first frame bit appears on `bit_out` after edge N+1, i.e. one cycle after accept. `bit_strobe` is high in that same cycle.
- Frame bit k occupies the cycles after edges N+1+kC through N+(k+1)C.
- After edge N+FC+1, the FSM is in IDLE with `bit_out`=0, `busy`=0, `data_ready`=1.
- Back-to-back: the earliest next accept is edge N+FC+1. Its first bit starts after N+FC+2, so consecutive frames are separated by exactly one idle cycle at `bit_out`=0.
- Simultaneous reset and accept: reset wins and the word is not accepted.
- `bit_out` never glitches within a bit period. It changes only on bit boundaries and on reset.

## Structure

- Shared package `bask_pkg` holds:
  - the state enum `frame_state_t` (IDLE, PREAMBLE, DATA, GUARD);
  - the default constants `BASK_CLKS_PER_BIT`=50 and `BASK_DATA_W`=8;
  - the preamble start level constant `BASK_PREAMBLE_FIRST`=1.
- One sub-module, `bit_timer`:
  - parameterised by `CLKS_PER_BIT`;
  - inputs `clk`, `rst` (synchronous active-low), `run`;
  - output `tick`, high on the last cycle of each bit;
  - the counter clears whenever `run`=0.
- The top level holds the FSM, shift register, bit index and output registers.
- Instantiated upstream of the BASK modulator, with `bit_out` connected to its `sel` input.

## Test plan

1. Reset: hold `rst`=0 for 3 cycles with `data_valid`=1. Required: `bit_out`=0, `busy`=0, `data_ready`=1, no `bit_strobe` pulse, nothing accepted.
2. Single frame, C=4, P=4, `data_in`=8'hA5:
   - `bit_out` = 1,0,1,0, 1,0,1,0,0,1,0,1, 0, each bit held 4 cycles;
   - the first bit starts 1 cycle after accept;
   - `bit_strobe` pulses 13 times, 4 cycles apart;
   - `busy` is high for 52 cycles.
3. Capture and ignore: change `data_in` to 8'hFF and pulse `data_valid` mid-frame. Required: the frame still carries 8'hA5, `data_ready` stays 0, and no second frame follows.
4. Back-to-back: hold `data_valid`=1 with words 8'h0F then 8'hF0. Required: exactly one idle cycle at `bit_out`=0 between the GUARD bit and the next preamble first bit.
5. Reset mid-frame: assert `rst`=0 during data bit 3. Required: `bit_out`=0 on the next edge, `data_ready`=1 after release, and a new accept sends a full fresh frame.
6. Boundary, P=0, C=2, `data_in`=8'h80:
   - required `bit_out` sequence is 1,0,0,0,0,0,0,0,0, each bit held 2 cycles;
   - `busy` is high for 18 cycles.

Source files
------------

// File: rtl/bask_pkg.sv
// Shared types and defaults for the BASK transmit path.
package bask_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      GUARD
   } frame_state_t;

   localparam int   BASK_CLKS_PER_BIT   = 50;
   localparam int   BASK_DATA_W         = 8;
   localparam logic BASK_PREAMBLE_FIRST = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit period timer: counts clock cycles within one frame bit while running.
module bit_timer
   import bask_pkg::*;
#(
   parameter int CLKS_PER_BIT = BASK_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Held at zero while idle so the first bit of a frame gets a full period.
   always_ff @(posedge clk) begin
      if (!rst || !run) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = run && (count == LAST);

endmodule

// File: rtl/bask_bit_framer.sv
// Frames parallel words (preamble, MSB-first data, guard bit) into a serial bit stream.
module bask_bit_framer
   import bask_pkg::*;
#(
   parameter int DATA_W       = BASK_DATA_W,
   parameter int CLKS_PER_BIT = BASK_CLKS_PER_BIT,
   parameter int PREAMBLE_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              bit_out,
   output logic              bit_strobe,
   output logic              busy
);

   localparam int            IW        = $clog2(max_int(PREAMBLE_LEN, DATA_W) + 1);
   localparam logic [IW-1:0] PRE_LAST  = IW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);

   frame_state_t      state;
   frame_state_t      state_next;
   logic [DATA_W-1:0] shreg;
   logic [IW-1:0]     bit_idx;
   logic              tick;
   logic              accept;
   logic              bit_first;
   logic              level;

   // Handshake: a word transfers on any rising edge with data_valid and data_ready both high.
   assign accept = data_valid && data_ready;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .run (busy),
      .tick(tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (PREAMBLE_LEN > 0) ? PREAMBLE : DATA;
            end
         end
         PREAMBLE: begin
            if (tick && (bit_idx == PRE_LAST)) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (tick && (bit_idx == DATA_LAST)) begin
               state_next = GUARD;
            end
         end
         GUARD: begin
            if (tick) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      data_ready = (state == IDLE);
      level      = 1'b0;
      case (state)
         PREAMBLE: level = BASK_PREAMBLE_FIRST ^ bit_idx[0];
         DATA:     level = shreg[DATA_W-1];
         default:  level = 1'b0;
      endcase
   end

   // Outputs trail the FSM by one register stage, so the first bit lands one cycle after accept.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg      <= '0;
         bit_idx    <= '0;
         bit_first  <= 1'b0;
         bit_out    <= 1'b0;
         bit_strobe <= 1'b0;
      end else begin
         bit_out    <= level;
         bit_strobe <= bit_first;
         bit_first  <= accept || (tick && (state_next != IDLE));
         if (accept) begin
            shreg   <= data_in;
            bit_idx <= '0;
         end else if (tick) begin
            if (state_next != state) begin
               bit_idx <= '0;
            end else begin
               bit_idx <= bit_idx + IW'(1);
            end
            if (state == DATA) begin
               shreg <= shreg << 1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bask_bit_framer.sv
// Directed bench for bask_bit_framer: per-cycle expected streams built from the frame format.
module tb_bask_bit_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data0, data1;
   logic       valid0, valid1;
   logic       ready0, bit0, stb0, busy0;
   logic       ready1, bit1, stb1, busy1;
   int         sel;

   logic [0:0] exp_bit_q[$];
   logic [0:0] exp_stb_q[$];
   logic [0:0] exp_busy_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int busy_cnt;
   int stb_cnt;

   always #5 clk = ~clk;

   bask_bit_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PREAMBLE_LEN(4)) u_dut0 (
      .clk(clk), .rst(rst), .data_in(data0), .data_valid(valid0),
      .data_ready(ready0), .bit_out(bit0), .bit_strobe(stb0), .busy(busy0)
   );

   bask_bit_framer #(.DATA_W(8), .CLKS_PER_BIT(2), .PREAMBLE_LEN(0)) u_dut1 (
      .clk(clk), .rst(rst), .data_in(data1), .data_valid(valid1),
      .data_ready(ready1), .bit_out(bit1), .bit_strobe(stb1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic push_busy(input logic v, input int n);
      for (int i = 0; i < n; i++) exp_busy_q.push_back(v);
   endtask

   task automatic push_gap(input int n);
      for (int i = 0; i < n; i++) begin
         exp_bit_q.push_back(1'b0);
         exp_stb_q.push_back(1'b0);
      end
   endtask

   // Frame bit k: alternating preamble from 1, then data MSB first, then a 0 guard bit.
   task automatic push_frame(input logic [7:0] w, input int p, input int c);
      logic lvl;
      for (int k = 0; k < p + 9; k++) begin
         if (k < p)          lvl = ((k % 2) == 0);
         else if (k < p + 8) lvl = w[7-(k-p)];
         else                lvl = 1'b0;
         for (int i = 0; i < c; i++) begin
            exp_bit_q.push_back(lvl);
            exp_stb_q.push_back(i == 0);
         end
      end
   endtask

   task automatic clear_q();
      exp_bit_q.delete();
      exp_stb_q.delete();
      exp_busy_q.delete();
   endtask

   task automatic check_cycles(input int n, input string name);
      logic ob, os, oy, orr, eb;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         ob  = (sel == 0) ? bit0 : bit1;
         os  = (sel == 0) ? stb0 : stb1;
         oy  = (sel == 0) ? busy0 : busy1;
         orr = (sel == 0) ? ready0 : ready1;
         eb  = exp_busy_q.pop_front();
         check($sformatf("%s bit_out c%0d", name, j), ob, exp_bit_q.pop_front());
         check($sformatf("%s bit_strobe c%0d", name, j), os, exp_stb_q.pop_front());
         check($sformatf("%s busy c%0d", name, j), oy, eb);
         check($sformatf("%s data_ready c%0d", name, j), orr, !eb);
         busy_cnt += oy;
         stb_cnt  += os;
      end
   endtask

   // Called just after a falling edge; returns 1 ns after the accept edge.
   task automatic send(input logic [7:0] w, input bit hold);
      if (sel == 0) begin
         data0  = w;
         valid0 = 1'b1;
      end else begin
         data1  = w;
         valid1 = 1'b1;
      end
      check("ready before accept", (sel == 0) ? ready0 : ready1, 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         valid0 = 1'b0;
         valid1 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sel    = 0;
      rst    = 1'b0;
      data0  = 8'h5A;
      data1  = 8'h5A;
      valid0 = 1'b1;
      valid1 = 1'b1;

      // Reset held with data_valid high: nothing may be accepted.
      clear_q();
      push_busy(0, 3);
      push_gap(3);
      check_cycles(3, "reset");
      check("reset u1 busy", busy1, 0);
      check("reset u1 ready", ready1, 1);
      valid0 = 1'b0;
      valid1 = 1'b0;
      rst    = 1'b1;
      push_busy(0, 2);
      push_gap(2);
      check_cycles(2, "post_reset");

      // Single frame of A5.
      clear_q();
      send(8'hA5, 1'b0);
      push_busy(1, 52);
      push_busy(0, 2);
      push_gap(1);
      push_frame(8'hA5, 4, 4);
      push_gap(1);
      busy_cnt = 0;
      stb_cnt  = 0;
      check_cycles(54, "single");
      check("single busy cycles", busy_cnt, 52);
      check("single strobe count", stb_cnt, 13);

      // Capture then ignore a mid-frame word.
      clear_q();
      send(8'hA5, 1'b0);
      push_busy(1, 52);
      push_busy(0, 6);
      push_gap(1);
      push_frame(8'hA5, 4, 4);
      push_gap(5);
      fork
         check_cycles(58, "capture");
         begin
            repeat (19) @(posedge clk);
            #1;
            data0  = 8'hFF;
            valid0 = 1'b1;
            @(negedge clk);
            check("ready mid-frame", ready0, 0);
            @(posedge clk);
            #1;
            valid0 = 1'b0;
         end
      join

      // Back-to-back with data_valid held high.
      clear_q();
      send(8'h0F, 1'b1);
      data0 = 8'hF0;
      push_busy(1, 52);
      push_busy(0, 1);
      push_busy(1, 52);
      push_busy(0, 2);
      push_gap(1);
      push_frame(8'h0F, 4, 4);
      push_gap(1);
      push_frame(8'hF0, 4, 4);
      push_gap(1);
      fork
         check_cycles(107, "b2b");
         begin
            repeat (53) @(posedge clk);
            #1;
            valid0 = 1'b0;
         end
      join

      // Reset during data bit 3 (frame bit 7), where F0 puts a 1 on the line.
      clear_q();
      send(8'hF0, 1'b0);
      push_busy(1, 52);
      push_gap(1);
      push_frame(8'hF0, 4, 4);
      check_cycles(31, "abort");
      clear_q();
      rst = 1'b0;
      @(negedge clk);
      check("abort bit_out", bit0, 0);
      check("abort busy", busy0, 0);
      check("abort ready", ready0, 1);
      check("abort strobe", stb0, 0);
      rst = 1'b1;
      @(negedge clk);
      check("after abort ready", ready0, 1);
      check("after abort bit_out", bit0, 0);
      send(8'h3C, 1'b0);
      push_busy(1, 52);
      push_busy(0, 2);
      push_gap(1);
      push_frame(8'h3C, 4, 4);
      push_gap(1);
      busy_cnt = 0;
      stb_cnt  = 0;
      check_cycles(54, "fresh");
      check("fresh busy cycles", busy_cnt, 52);

      // No preamble, two clocks per bit.
      clear_q();
      sel = 1;
      send(8'h80, 1'b0);
      push_busy(1, 18);
      push_busy(0, 2);
      push_gap(1);
      push_frame(8'h80, 0, 2);
      push_gap(1);
      busy_cnt = 0;
      stb_cnt  = 0;
      check_cycles(20, "p0");
      check("p0 busy cycles", busy_cnt, 18);
      check("p0 strobe count", stb_cnt, 9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
